// File: rtl/score_sequencer.sv
// ============================================================================
// Module  : score_sequencer
// Brief   : Note-by-note judgement sequencer around an external Scoring unit.
//           Optional consecutive-miss failure enabled by SCORE_SEQ_FAIL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module score_sequencer #(
    parameter int T_W         = 20,
    parameter int MISS_WIN    = 188,
    parameter int FAIL_MISSES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [20:0]    total_note,
    input  logic [1:0]     mod,
    input  logic [3:0]     difficulty,
    input  logic [T_W-1:0] game_time,
    input  logic           chart_valid,
    output logic           chart_ready,
    input  logic [T_W-1:0] chart_time,
    input  logic [2:0]     chart_octave,
    input  logic [3:0]     chart_note,
    input  logic [2:0]     chart_len,
    input  logic           hit_valid,
    output logic           hit_ready,
    input  logic [T_W-1:0] hit_time,
    input  logic [2:0]     hit_octave,
    input  logic [3:0]     hit_note,
    input  logic [2:0]     hit_len,
    output logic [T_W-1:0] sc_clock,
    output logic [2:0]     sc_octave,
    output logic [3:0]     sc_note,
    output logic [2:0]     sc_length,
    output logic [T_W-1:0] sc_goal_clock,
    output logic [2:0]     sc_goal_octave,
    output logic [3:0]     sc_goal_note,
    output logic [2:0]     sc_goal_length,
    output logic [20:0]    sc_last_combo,
    output logic [20:0]    sc_now_cnt,
    output logic [20:0]    sc_total_note,
    output logic [1:0]     sc_mod,
    output logic [3:0]     sc_difficutly,
    output logic [23:0]    sc_last_base_score,
    input  logic [20:0]    sc_base,
    input  logic [20:0]    sc_bonus,
    input  logic [20:0]    sc_combo,
    input  logic [20:0]    sc_acc,
    input  logic [2:0]     sc_level,
    output logic [23:0]    total_score,
    output logic [20:0]    combo,
    output logic [20:0]    max_combo,
    output logic [20:0]    note_cnt,
    output logic [20:0]    acc,
    output logic [2:0]     level,
    output logic           busy,
    output logic           done,
    output logic           fail
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_EVAL   = 3'd3;
    localparam logic [2:0] c_COMMIT = 3'd4;
    localparam logic [2:0] c_END    = 3'd5;
    localparam logic [2:0] c_LEVEL_RST = 3'd6;

    logic [2:0]  r_state;
    logic [23:0] r_base_acc;

    logic [T_W:0]  w_deadline;
    logic          w_timeout;
    logic [24:0]   w_score_sum;
    logic [24:0]   w_base_sum;
    logic [20:0]   w_cnt_inc;
    logic          w_last_note;
    logic          w_start_ok;
    logic          w_fail_now;

    // Extra top bit keeps the late-window deadline from wrapping near the end of time.
    assign w_deadline  = {1'b0, sc_goal_clock} + (T_W+1)'(MISS_WIN);
    assign w_timeout   = {1'b0, game_time} > w_deadline;
    assign w_score_sum = {1'b0, total_score} + 25'(sc_base) + 25'(sc_bonus);
    assign w_base_sum  = {1'b0, r_base_acc} + 25'(sc_base);
    assign w_cnt_inc   = note_cnt + 21'd1;
    assign w_last_note = (w_cnt_inc == sc_total_note);
    assign w_start_ok  = start && ((r_state == c_IDLE) || (r_state == c_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= c_IDLE;
            chart_ready        <= 1'b0;
            hit_ready          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            sc_clock           <= '0;
            sc_octave          <= '0;
            sc_note            <= '0;
            sc_length          <= '0;
            sc_goal_clock      <= '0;
            sc_goal_octave     <= '0;
            sc_goal_note       <= '0;
            sc_goal_length     <= '0;
            sc_last_combo      <= '0;
            sc_now_cnt         <= '0;
            sc_total_note      <= '0;
            sc_mod             <= '0;
            sc_difficutly      <= '0;
            sc_last_base_score <= '0;
            r_base_acc         <= '0;
            total_score        <= '0;
            combo              <= '0;
            max_combo          <= '0;
            note_cnt           <= '0;
            acc                <= '0;
            level              <= c_LEVEL_RST;
        end else begin
            case (r_state)
                c_IDLE, c_END: begin
                    if (start) begin
                        r_base_acc    <= '0;
                        total_score   <= '0;
                        combo         <= '0;
                        max_combo     <= '0;
                        note_cnt      <= '0;
                        acc           <= '0;
                        level         <= c_LEVEL_RST;
                        sc_total_note <= total_note;
                        sc_mod        <= mod;
                        sc_difficutly <= difficulty;
                        chart_ready   <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        r_state       <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (chart_valid && chart_ready) begin
                        sc_goal_clock  <= chart_time;
                        sc_goal_octave <= chart_octave;
                        sc_goal_note   <= chart_note;
                        sc_goal_length <= chart_len;
                        chart_ready    <= 1'b0;
                        hit_ready      <= 1'b1;
                        r_state        <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if ((hit_valid && hit_ready) || w_timeout) begin
                        sc_last_combo      <= combo;
                        sc_now_cnt         <= w_cnt_inc;
                        sc_last_base_score <= r_base_acc;
                        hit_ready          <= 1'b0;
                        r_state            <= c_EVAL;
                        if (hit_valid && hit_ready) begin
                            sc_clock  <= hit_time;
                            sc_octave <= hit_octave;
                            sc_note   <= hit_note;
                            sc_length <= hit_len;
                        end else begin
                            // Inverted octave guarantees the scorer sees a non-matching note.
                            sc_clock  <= game_time;
                            sc_octave <= ~sc_goal_octave;
                            sc_note   <= sc_goal_note;
                            sc_length <= sc_goal_length;
                        end
                    end
                end
                c_EVAL: begin
                    r_state <= c_COMMIT;
                end
                c_COMMIT: begin
                    total_score <= w_score_sum[24] ? 24'hFF_FFFF : w_score_sum[23:0];
                    r_base_acc  <= w_base_sum[24]  ? 24'hFF_FFFF : w_base_sum[23:0];
                    combo       <= sc_combo;
                    max_combo   <= (sc_combo > max_combo) ? sc_combo : max_combo;
                    note_cnt    <= w_cnt_inc;
                    acc         <= sc_acc;
                    level       <= sc_level;
                    if (w_last_note || w_fail_now) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= c_END;
                    end else begin
                        chart_ready <= 1'b1;
                        r_state     <= c_FETCH;
                    end
                end
                default: begin
                    chart_ready <= 1'b0;
                    hit_ready   <= 1'b0;
                    busy        <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

`ifdef SCORE_SEQ_FAIL_EN
    localparam int c_CNT_W = $clog2(FAIL_MISSES + 1);

    logic [c_CNT_W-1:0] r_miss_cnt;
    logic               r_fail;
    logic               w_zero;

    assign w_zero     = (sc_base == 21'd0);
    assign w_fail_now = w_zero && ((32'(r_miss_cnt) + 32'd1) >= 32'(FAIL_MISSES)) &&
                        (sc_mod != 2'b01);
    assign fail       = r_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_cnt <= '0;
            r_fail     <= 1'b0;
        end else if (w_start_ok) begin
            r_miss_cnt <= '0;
            r_fail     <= 1'b0;
        end else if (r_state == c_COMMIT) begin
            if (!w_zero) begin
                r_miss_cnt <= '0;
            end else if (r_miss_cnt != c_CNT_W'(FAIL_MISSES)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
            if (w_fail_now) begin
                r_fail <= 1'b1;
            end
        end
    end
`else
    logic w_start_unused;

    assign w_start_unused = w_start_ok;
    assign w_fail_now     = 1'b0;
    // FAIL_MISSES is only meaningful in the failure-enabled build.
    assign fail           = (FAIL_MISSES < 0) & w_start_unused;
`endif

endmodule

`default_nettype wire

// File: tb/tb_score_sequencer.sv
// ============================================================================
// Module  : tb_score_sequencer
// Brief   : Directed scoreboard bench for score_sequencer with a behavioural
//           Scoring unit driving the sc_* result inputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_sequencer;

    localparam int T_W = 20;

    logic           clk = 1'b0;
    logic           rst_n, start;
    logic [20:0]    total_note;
    logic [1:0]     mod;
    logic [3:0]     difficulty;
    logic [T_W-1:0] game_time;
    logic           chart_valid, chart_ready;
    logic [T_W-1:0] chart_time;
    logic [2:0]     chart_octave, chart_len;
    logic [3:0]     chart_note;
    logic           hit_valid, hit_ready;
    logic [T_W-1:0] hit_time;
    logic [2:0]     hit_octave, hit_len;
    logic [3:0]     hit_note;
    logic [T_W-1:0] sc_clock, sc_goal_clock;
    logic [2:0]     sc_octave, sc_length, sc_goal_octave, sc_goal_length;
    logic [3:0]     sc_note, sc_goal_note, sc_difficutly;
    logic [20:0]    sc_last_combo, sc_now_cnt, sc_total_note;
    logic [1:0]     sc_mod;
    logic [23:0]    sc_last_base_score;
    logic [20:0]    sc_base, sc_bonus, sc_combo, sc_acc;
    logic [2:0]     sc_level;
    logic [23:0]    total_score;
    logic [20:0]    combo, max_combo, note_cnt, acc;
    logic [2:0]     level;
    logic           busy, done, fail;

    always #5 clk = ~clk;

    score_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .total_note(total_note), .mod(mod),
        .difficulty(difficulty), .game_time(game_time),
        .chart_valid(chart_valid), .chart_ready(chart_ready), .chart_time(chart_time),
        .chart_octave(chart_octave), .chart_note(chart_note), .chart_len(chart_len),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_time(hit_time),
        .hit_octave(hit_octave), .hit_note(hit_note), .hit_len(hit_len),
        .sc_clock(sc_clock), .sc_octave(sc_octave), .sc_note(sc_note), .sc_length(sc_length),
        .sc_goal_clock(sc_goal_clock), .sc_goal_octave(sc_goal_octave),
        .sc_goal_note(sc_goal_note), .sc_goal_length(sc_goal_length),
        .sc_last_combo(sc_last_combo), .sc_now_cnt(sc_now_cnt), .sc_total_note(sc_total_note),
        .sc_mod(sc_mod), .sc_difficutly(sc_difficutly), .sc_last_base_score(sc_last_base_score),
        .sc_base(sc_base), .sc_bonus(sc_bonus), .sc_combo(sc_combo), .sc_acc(sc_acc),
        .sc_level(sc_level), .total_score(total_score), .combo(combo), .max_combo(max_combo),
        .note_cnt(note_cnt), .acc(acc), .level(level), .busy(busy), .done(done), .fail(fail)
    );

    // Stand-in Scoring unit: an exact match scores 900+100 and grows combo by 2.
    logic w_match;
    always_comb begin
        w_match  = (sc_clock == sc_goal_clock) && (sc_octave == sc_goal_octave) &&
                   (sc_note == sc_goal_note) && (sc_length == sc_goal_length);
        sc_base  = w_match ? 21'd900 : 21'd0;
        sc_bonus = w_match ? 21'd100 : 21'd0;
        sc_combo = w_match ? sc_last_combo + 21'd2 : 21'd0;
        sc_acc   = w_match ? 21'd100 : 21'd0;
        sc_level = w_match ? 3'd0 : 3'd5;
    end

    typedef struct {
        int prev_total;
        int total;
        int combo;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_total, exp_combo, exp_cnt, exp_max;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        exp_total = 0;
        exp_combo = 0;
        exp_cnt   = 0;
        exp_max   = 0;
        sb.delete();
    endtask

    task automatic start_song(input int n, input logic [1:0] m);
        start      = 1'b1;
        total_note = 21'(n);
        mod        = m;
        difficulty = 4'd3;
        step();
        start = 1'b0;
        clear_model();
    endtask

    // kind: 0 exact hit, 1 timeout miss, 2 hit coinciding with timeout, 3 wrong-octave hit
    task automatic accept_note(input int ct, input int kind);
        logic good;
        exp_t e;
        for (int i = 0; i < 20 && chart_ready !== 1'b1; i++) step();
        check("chart_ready_wait", chart_ready, 1);
        chart_valid  = 1'b1;
        chart_time   = T_W'(ct);
        chart_octave = 3'(ct / 1000 % 7);
        chart_note   = 4'(ct / 1000 % 12);
        chart_len    = 3'd2;
        game_time    = T_W'(ct);
        step();
        chart_valid = 1'b0;
        for (int i = 0; i < 20 && hit_ready !== 1'b1; i++) step();
        check("hit_ready_wait", hit_ready, 1);
        hit_time   = T_W'(ct);
        hit_octave = (kind == 3) ? chart_octave + 3'd1 : chart_octave;
        hit_note   = chart_note;
        hit_len    = chart_len;
        case (kind)
            1: begin
                game_time = T_W'(ct + 188);
                step();
                check("no_timeout_at_188", hit_ready, 1);
                game_time = T_W'(ct + 189);
                step();
            end
            2: begin
                game_time = T_W'(ct + 189);
                hit_valid = 1'b1;
                step();
                hit_valid = 1'b0;
            end
            default: begin
                hit_valid = 1'b1;
                step();
                hit_valid = 1'b0;
            end
        endcase
        good         = (kind == 0) || (kind == 2);
        e.prev_total = exp_total;
        exp_total    = exp_total + (good ? 1000 : 0);
        exp_combo    = good ? exp_combo + 2 : 0;
        exp_cnt      = exp_cnt + 1;
        if (exp_combo > exp_max) exp_max = exp_combo;
        e.total = exp_total;
        e.combo = exp_combo;
        e.cnt   = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic finish_note();
        exp_t e;
        e = sb.pop_front();
        check("now_cnt_eval", sc_now_cnt, e.cnt);
        step();
        check("score_hold_1cyc", total_score, e.prev_total);
        step();
        check("total_score", total_score, e.total);
        check("combo", combo, e.combo);
        check("note_cnt", note_cnt, e.cnt);
    endtask

    task automatic play(input int ct, input int kind);
        accept_note(ct, kind);
        finish_note();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; total_note = '0; mod = '0; difficulty = '0;
        game_time = '0; chart_valid = 1'b0; chart_time = '0; chart_octave = '0;
        chart_note = '0; chart_len = '0; hit_valid = 1'b0; hit_time = '0;
        hit_octave = '0; hit_note = '0; hit_len = '0;
        clear_model();
        step();
        step();
        check("rst_total", total_score, 0);
        check("rst_level", level, 6);
        check("rst_busy", busy, 0);
        check("rst_chart_ready", chart_ready, 0);
        check("rst_fail", fail, 0);
        rst_n = 1'b1;
        step();

        // Song 1: hit, miss, coincident hit/timeout, mismatch, then six hits.
        start_song(10, 2'b00);
        check("busy_after_start", busy, 1);
        play(1000, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored", note_cnt, 1);
        play(2000, 1);
        play(3000, 2);
        play(4000, 3);
        for (int k = 0; k < 6; k++) play(5000 + 1000 * k, 0);
        check("s1_done", done, 1);
        check("s1_busy", busy, 0);
        check("s1_max_combo", max_combo, exp_max);
        step();
        step();
        check("s1_chart_ready_end", chart_ready, 0);
        check("s1_hold_total", total_score, 8000);

        // Song 2: ten perfect hits, restarted straight out of END.
        start_song(10, 2'b00);
        check("s2_cleared_total", total_score, 0);
        check("s2_cleared_done", done, 0);
        for (int k = 0; k < 10; k++) play(20000 + 1000 * k, 0);
        check("s2_done", done, 1);
        check("s2_max_combo", max_combo, 20);
        check("s2_acc", acc, 100);
        check("s2_level", level, 0);
        step();
        check("s2_chart_ready_end", chart_ready, 0);

        // Song 3: eight straight misses in Normal mode.
        start_song(10, 2'b00);
        for (int k = 0; k < 8; k++) play(40000 + 1000 * k, 1);
        check("s3_level", level, 5);
`ifdef SCORE_SEQ_FAIL_EN
        check("s3_fail", fail, 1);
        check("s3_done", done, 1);
`else
        check("s3_fail_off", fail, 0);
        check("s3_done_off", done, 0);
`endif
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();

        // Song 4: No Fail mode never fails; then reset lands in EVAL.
        start_song(10, 2'b01);
        for (int k = 0; k < 8; k++) play(60000 + 1000 * k, 1);
        check("s4_fail", fail, 0);
        check("s4_done", done, 0);
        play(70000, 0);
        accept_note(71000, 0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("evrst_total", total_score, 0);
        check("evrst_note_cnt", note_cnt, 0);
        check("evrst_combo", combo, 0);
        check("evrst_max_combo", max_combo, 0);
        check("evrst_level", level, 6);
        check("evrst_busy", busy, 0);
        check("evrst_now_cnt", sc_now_cnt, 0);
        #2;
        rst_n = 1'b1;
        step();
        check("evrst_idle_busy", busy, 0);
        check("evrst_idle_chart_ready", chart_ready, 0);
        check("evrst_idle_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_sequencer.md
SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 The block SHALL have parameter T_W, default 20, as the width of game-time and goal-time values.
REQ-002 The block SHALL have parameter MISS_WIN, default 188, as the late window in ticks after which an unhit goal note counts as a miss.
REQ-003 The block SHALL have parameter FAIL_MISSES, default 8, as the number of consecutive misses that ends the song in failure.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin a song
- total_note  in  21  number of chart notes; 0 is illegal
- mod  in  2  game mode: 00 Normal, 01 No Fail, 10 Half Time, 11 Double Time
- difficulty  in  4  difficulty level
- game_time  in  T_W  current song time in ticks
- chart_valid / chart_ready  in / out  1  goal-note handshake
- chart_time, chart_octave, chart_note, chart_len  in  T_W/3/4/3  goal note fields
- hit_valid / hit_ready  in / out  1  player-hit handshake
- hit_time, hit_octave, hit_note, hit_len  in  T_W/3/4/3  played note fields
- sc_* (clock, octave, note, length, goal_*, last_combo, now_cnt, total_note, mod, difficutly, last_base_score)  out  matching widths  registered operands to the external Scoring instance
- sc_base, sc_bonus, sc_combo, sc_acc, sc_level  in  21/21/21/21/3  Scoring results
- total_score  out  24  running sum of base and bonus
- combo, max_combo, note_cnt  out  21  current combo, best combo, judged notes
- acc  out  21  accuracy; level  out  3  grade
- busy, done, fail  out  1  status

Function
REQ-005 The block SHALL use the states IDLE, FETCH, WAIT, EVAL, COMMIT and END.
REQ-006 IDLE: on start, the block SHALL clear all accumulators, latch total_note, mod and difficulty, and go to FETCH; start SHALL be ignored in every other state.
REQ-007 FETCH: chart_ready SHALL be 1; when chart_valid and chart_ready are both 1, the block SHALL latch the goal fields and go to WAIT.
REQ-008 WAIT: hit_ready SHALL be 1; when a hit is accepted, the block SHALL drive the hit fields onto the sc_* operands and go to EVAL.
REQ-009 WAIT: if no hit is accepted and game_time > chart_time + MISS_WIN (compared at T_W+1 bits, no wrap), the block SHALL record a miss and go to EVAL with an operand octave that cannot match the goal, forcing a zero score.
REQ-010 WAIT: if a hit is accepted and the miss timeout occurs in the same cycle, the hit SHALL take precedence.
REQ-011 The sc_* operands SHALL be stable from EVAL through COMMIT: last_combo = combo, now_cnt = note_cnt+1, last_base_score = accumulated base.
REQ-012 EVAL SHALL take one cycle, settling the combinational datapath.
REQ-013 COMMIT SHALL sample the sc_* results and update the block as follows:
- total_score += sc_base + sc_bonus, saturating at 2^24-1
- combo = sc_combo; max_combo = max(max_combo, sc_combo)
- note_cnt += 1; acc and level from sc_acc and sc_level
REQ-014 COMMIT SHALL then go to END if note_cnt equals total_note, otherwise to FETCH.
REQ-015 Latency from hit acceptance to the updated total_score SHALL be exactly 2 cycles.
REQ-016 A hit whose fields mismatch the goal SHALL consume the goal note and reset combo to 0.
REQ-017 END: done SHALL be 1 and the outputs SHALL hold until the next start, which re-enters FETCH with cleared accumulators.
REQ-018 busy SHALL be 1 in every state except IDLE and END.

Reset
REQ-019 On rst_n = 0, the block SHALL immediately enter IDLE with every output, counter and latched field at 0, and level at 6.
REQ-020 A reset asserted mid-song SHALL discard the in-flight note with no partial commit.

Configuration
REQ-021 With SCORE_SEQ_FAIL_EN defined, a consecutive-miss counter SHALL count misses and zero-score judgements and clear on any nonzero sc_base.
REQ-022 With SCORE_SEQ_FAIL_EN defined, when the counter reaches FAIL_MISSES and mod is not 01, the block SHALL set fail = 1 and go to END after COMMIT.
REQ-023 Without SCORE_SEQ_FAIL_EN, fail SHALL be tied to 0 and no counter SHALL exist.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- start with total_note = 10, mod = 00, exact hit at chart_time -> after 2 cycles total_score = 1000, combo = 2, note_cnt = 1
- no hit until game_time = chart_time + 189 -> miss committed, combo = 0, total_score unchanged
- hit and timeout in the same cycle -> hit judged, not a miss
- SCORE_SEQ_FAIL_EN defined, 8 misses, mod = 00 -> fail = 1, done = 1; with mod = 01 -> fail stays 0
- 10 perfect hits -> done = 1 after the 10th COMMIT, max_combo = 20, chart_ready stays 0 in END
- rst_n pulsed during EVAL -> all outputs 0, level = 6, state IDLE next edge
